// File: rtl/multicycle_ctrl.sv
// Purpose: main control FSM of the multi-cycle RV32I core (datapath selects, enables, ALU op).
// Latency: 3-5 cycles per instruction with mem_ready held high; outputs are decoded from state.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while mem_ready=0, one extra cycle per low cycle.
//
// Ports:
//   clk, rst_n                        core clock, async active-low reset
//   opcode, funct3, funct7b5, zero    instruction fields and ALU zero flag
//   mem_ready                         memory completes current access this cycle
//   pc_write, adr_src, mem_write,     datapath enables and mux selects
//   ir_write, result_src, alu_src_a,
//   alu_src_b, imm_src, alu_control,
//   reg_write
//   illegal                           sticky trap indicator (unsupported opcode)
//   state_o                           current state, for debug
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    JALR     = 4'd11,
    JALR_PC  = 4'd12,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t     state;
  logic [2:0] alu_func;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= state_t'(RESET_STATE);
    end else begin
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_R:              state <= EXECR;
            OP_I:              state <= EXECI;
            OP_BRANCH:         state <= BRANCH;
            OP_JAL:            state <= JAL;
            OP_JALR:           state <= JALR;
            default:           state <= TRAP;
          endcase
        end
        MEMADR:   state <= (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        JAL:      state <= ALUWB;
        JALR:     state <= JALR_PC;
        JALR_PC:  state <= ALUWB;
        TRAP:     state <= TRAP;
        // 13 and 14 are not real states; fall into the trap.
        default:  state <= TRAP;
      endcase
    end
  end

  // Function-class ALU op shared by EXECR and EXECI; only R-type honours
  // funct7b5 so that addi with a negative immediate is not turned into sub.
  always_comb begin
    alu_func = 3'b000;
    case (funct3)
      3'b000:  alu_func = (opcode == OP_R && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_func = 3'b101;
      3'b110:  alu_func = 3'b011;
      3'b111:  alu_func = 3'b010;
      default: alu_func = 3'b000;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    reg_write   = 1'b0;
    illegal     = 1'b0;

    case (opcode)
      OP_LOAD, OP_JALR, OP_I: imm_src = 2'b00;
      OP_STORE:               imm_src = 2'b01;
      OP_BRANCH:              imm_src = 2'b10;
      OP_JAL:                 imm_src = 2'b11;
      default:                imm_src = 2'b00;
    endcase

    case (state)
      FETCH: begin
        pc_write   = mem_ready;
        ir_write   = mem_ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_func;
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_func;
      end
      ALUWB:    reg_write = 1'b1;
      BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          default: pc_write = 1'b0;
        endcase
      end
      JAL, JALR_PC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      TRAP:     illegal = 1'b1;
      default:  ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its list of
// architectural steps; wait steps repeat while mem_ready is low.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;
  int q[$];
  int ncyc;
  int irw_cnt;
  int trapcnt;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
    .reg_write(reg_write), .illegal(illegal), .state_o(state_o)
  );

  wire [16:0] outs = {pc_write, adr_src, mem_write, ir_write, result_src,
                      alu_src_a, alu_src_b, imm_src, alu_control, reg_write, illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control word for one cycle, from the per-state meaning.
  function automatic logic [16:0] exp_outs(int st, logic [6:0] op, logic [2:0] f3,
                                           logic f7, logic z, logic rdy);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu, fn;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 0; a = 0; b = 0; imm = 0; alu = 0;
    if (op == 7'h03 || op == 7'h67 || op == 7'h13) imm = 2'b00;
    else if (op == 7'h23) imm = 2'b01;
    else if (op == 7'h63) imm = 2'b10;
    else if (op == 7'h6F) imm = 2'b11;
    if (f3 == 3'b000)      fn = (op == 7'h33 && f7) ? 3'b001 : 3'b000;
    else if (f3 == 3'b010) fn = 3'b101;
    else if (f3 == 3'b110) fn = 3'b011;
    else if (f3 == 3'b111) fn = 3'b010;
    else                   fn = 3'b000;
    case (st)
      0:  begin irw = rdy; pcw = rdy; b = 2; rs = 2; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2; alu = fn; end
      7:  rw = 1;
      8:  begin a = 2; b = 1; alu = fn; end
      9:  begin a = 1; b = 2; pcw = 1; end
      10: begin a = 2; alu = 3'b001; pcw = (f3 == 0) ? z : (f3 == 1) ? !z : 1'b0; end
      11: begin a = 2; b = 1; end
      12: begin a = 1; b = 2; pcw = 1; end
      15: ill = 1;
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, a, b, imm, alu, rw, ill};
  endfunction

  task automatic start_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z);
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
    q = {0, 1};
    case (op)
      7'h03:   q = {q, 2, 3, 4};
      7'h23:   q = {q, 2, 5};
      7'h33:   q = {q, 6, 7};
      7'h13:   q = {q, 8, 7};
      7'h63:   q = {q, 10};
      7'h6F:   q = {q, 9, 7};
      7'h67:   q = {q, 11, 12, 7};
      default: q = {q, 15};
    endcase
  endtask

  task automatic cycle(input logic rdy);
    int st;
    @(negedge clk);
    mem_ready = rdy;
    #1;
    if (q.size() == 0) begin
      $display("FAIL model_empty t=%0t", $time);
      $fatal(1);
    end
    st = q[0];
    chk("state", {28'd0, state_o}, st);
    chk("outs", {15'd0, outs}, {15'd0, exp_outs(st, opcode, funct3, funct7b5, zero, rdy)});
    if (ir_write) irw_cnt++;
    ncyc++;
    if (!(st == 15 || ((st == 0 || st == 3 || st == 5) && !rdy)))
      void'(q.pop_front());
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int exp_cycles);
    start_instr(op, f3, f7, z);
    ncyc = 0;
    while (q.size() != 0 && ncyc < 50) cycle(1'b1);
    chk("cycles", ncyc, exp_cycles);
  endtask

  // Called just after a negedge check; asserts reset before the next posedge.
  task automatic reset_check();
    #1 rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("rst_state", {28'd0, state_o}, 0);
    chk("rst_illegal", {31'd0, illegal}, 0);
    chk("rst_outs", {15'd0, outs}, {15'd0, exp_outs(0, opcode, funct3, funct7b5, zero, 1'b1)});
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [6:0] ops [7];
    logic [1:0] lw_rdy_pat;
    bit pat [10];
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67};
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'h33; funct3 = 0; funct7b5 = 0; zero = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", {28'd0, state_o}, 0);
    chk("reset_illegal", {31'd0, illegal}, 0);
    rst_n = 1'b1;

    // add, sub
    run_instr(7'h33, 3'b000, 1'b0, 1'b0, 4);
    run_instr(7'h33, 3'b000, 1'b1, 1'b0, 4);

    // lw with 2 FETCH stalls and 3 MEMREAD stalls: 0,0,0,1,2,3,3,3,3,4
    pat = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    start_instr(7'h03, 3'b010, 1'b0, 1'b0);
    ncyc = 0; irw_cnt = 0;
    foreach (pat[i]) cycle(pat[i]);
    chk("lw_cycles_done", q.size(), 0);
    chk("lw_irwrite", irw_cnt, 1);

    // sw with stalls in MEMWRITE
    start_instr(7'h23, 3'b010, 1'b0, 1'b0);
    ncyc = 0;
    cycle(1); cycle(1); cycle(1); cycle(0); cycle(0); cycle(1);
    chk("sw_done", q.size(), 0);

    // branches, jal, jalr, op-imm
    run_instr(7'h63, 3'b000, 1'b0, 1'b1, 3);
    run_instr(7'h63, 3'b000, 1'b0, 1'b0, 3);
    run_instr(7'h63, 3'b001, 1'b0, 1'b0, 3);
    run_instr(7'h63, 3'b001, 1'b0, 1'b1, 3);
    run_instr(7'h6F, 3'b000, 1'b0, 1'b0, 4);
    run_instr(7'h67, 3'b000, 1'b0, 1'b0, 5);
    run_instr(7'h13, 3'b000, 1'b1, 1'b0, 4);
    run_instr(7'h03, 3'b010, 1'b0, 1'b0, 5);
    run_instr(7'h23, 3'b010, 1'b0, 1'b0, 4);

    // reset in the middle of MEMREAD
    start_instr(7'h03, 3'b010, 1'b0, 1'b0);
    cycle(1); cycle(1); cycle(1); cycle(0);
    reset_check();
    run_instr(7'h33, 3'b111, 1'b0, 1'b0, 4);

    // illegal opcode traps and stays
    start_instr(7'h00, 3'b000, 1'b0, 1'b0);
    repeat (3) cycle(1);
    repeat (4) cycle(1'($urandom));
    chk("trap_sticky", {31'd0, illegal}, 1);
    reset_check();

    // randomized instruction stream with random memory stalls
    trapcnt = 0;
    repeat (1500) begin
      if (q.size() == 0) begin
        int k;
        logic [6:0] op;
        k = $urandom_range(0, 7);
        if (k < 7) op = ops[k];
        else begin
          op = 7'($urandom);
          foreach (ops[j]) if (op == ops[j]) op = 7'h00;
        end
        start_instr(op, 3'($urandom), 1'($urandom), 1'($urandom));
      end
      if (q[0] == 15 && trapcnt >= 3) begin
        reset_check();
        trapcnt = 0;
      end else begin
        if (q[0] == 15) trapcnt++;
        cycle($urandom_range(0, 3) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
